stepper_control_fsm: RTL
========================

Name: stepper_control_fsm

Overview:
Main controller for the stepper-motor ASIP datapath. It fetches each instruction from the synchronous instruction ROM and reads the one-hot decoder flags. It then drives every datapath control strobe: register-file write, operand/result muxes, ALU mode, PC, temp register and delay counter. It also sequences the multi-cycle instructions (stepping moves, absolute move, pause) using the temp register and delay counter.

Parameters:
ROM_LATENCY, 1, cycles from a PC update to a valid instruction at the decoder (1..3)
FULL_STEP, 2, position increment per iteration for movr (half-step ROM: 8 phases)
HALF_STEP, 1, position increment per iteration for movrhs

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = execute program; 0 = hold in FETCH after the current instruction retires
br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause  in  1 each  decoder flags
delay_done  in  1  delay counter expired
temp_is_positive, temp_is_negative, temp_is_zero  in  1 each  temp register sign
register0_is_zero  in  1  branch-condition flag
write_reg_file, result_mux_select  out  1 each
op1_mux_select, op2_mux_select  out  2 each
start_delay_counter, enable_delay_counter  out  1 each
commit_branch, increment_pc  out  1 each
alu_add_sub, alu_set_low, alu_set_high  out  1 each
load_temp, increment_temp, decrement_temp  out  1 each
select_immediate, select_write_address  out  2 each
state  out  4  current state, for debug/test

Behaviour:
- State is registered. Outputs are combinational from state plus the flags. Any output not named in a state is 0.
- Reset has priority over everything, including mid-move. While reset=1: state=FETCH, fetch counter=0, all outputs 0. PC reset belongs to the pc block.
- FETCH: counts ROM_LATENCY cycles. If run=1 when the count completes, go to EXEC; otherwise stay in FETCH.
- EXEC handles single-cycle instructions, which retire with increment_pc=1 and return to FETCH:
  - addi/subi: op1=REG, op2=IMM, select_immediate=IMM_ARITH, alu_add_sub=0/1, write WA_F0.
  - sr0/srh0: op1=R0, IMM_NIBBLE, alu_set_low/alu_set_high, write WA_R0.
  - clr: op1=REG, op2=REG, alu_add_sub=1 (x-x=0), write WA_F0.
  - mov: op1=REG, op2=IMM_ZERO, add, write WA_F1.
  - Writes use result_mux_select=0 (ALU).
- Branches (in EXEC):
  - br: op1=PC, op2=IMM, IMM_BR, add, commit_branch=1, increment_pc=0.
  - brz: as br if register0_is_zero=1; otherwise increment_pc only.
  - Next state FETCH in both cases.
- Illegal flag pattern (no flag, or more than one): treated as NOP, increment_pc=1. Priority order is br > brz > the rest.
- movr/movrhs:
  - EXEC asserts load_temp (temp <= selected0, signed step count), then goes to MOVE_CHECK.
  - MOVE_CHECK: if temp_is_zero, increment_pc and go to FETCH.
  - MOVE_CHECK, positive temp: op1=POS, op2=IMM with IMM_STEP, add, write WA_POS, decrement_temp, start_delay_counter, go to MOVE_WAIT.
  - MOVE_CHECK, negative temp: same but subtract and increment_temp.
  - IMM_STEP carries FULL_STEP for movr and HALF_STEP for movrhs; the step size is latched in EXEC.
  - MOVE_WAIT: enable_delay_counter=1 until delay_done, then back to MOVE_CHECK.
  - Position wraps modulo 256; the ROM uses position[2:0].
  - A count of N takes N*(delay+2)+1 cycles after EXEC.
- mova: EXEC writes position <= selected0 (op1=REG, IMM_ZERO, WA_POS) and pulses start_delay_counter, then goes to PAUSE_WAIT.
- pause: EXEC pulses start_delay_counter, then goes to PAUSE_WAIT.
- PAUSE_WAIT: enable_delay_counter until delay_done, then increment_pc and go to FETCH.
- delay_done in the same cycle as start is ignored; only WAIT states sample it.
- run=0 never aborts an instruction in progress.

Decomposition:
- Package stepper_ctrl_pkg holds:
  - state enum: FETCH, EXEC, MOVE_CHECK, MOVE_WAIT, PAUSE_WAIT
  - op1 codes: PC=0, REG=1, R0=2, POS=3
  - op2 codes: REG=0, IMM=1
  - immediate codes: IMM_BR, IMM_ARITH, IMM_NIBBLE, IMM_STEP / IMM_ZERO
  - write-address codes: WA_F0, WA_F1, WA_POS, WA_R0
  - latency and step constants
- One sub-module, ctrl_output_decode: purely combinational state+flags -> strobes. The FSM itself keeps state and counters.

Test Plan:
- Reset mid-MOVE_WAIT with temp=3 -> next cycle state=FETCH, every strobe 0, no further write_reg_file.
- Fetch/EXEC timing: addi flag with run=1, ROM_LATENCY=1 -> EXEC in cycle 2 after reset release with write_reg_file=1, op2=IMM, increment_pc=1; state back to FETCH next cycle.
- brz: register0_is_zero=1 -> commit_branch=1, increment_pc=0. Repeat with 0 -> increment_pc=1, commit_branch=0.
- movr with temp=+2, delay_done 4 cycles after each start -> exactly 2 position writes (add), 2 decrement_temp, 2 start pulses, then increment_pc. With temp=-1 -> 1 subtract, 1 increment_temp. movrhs selects step 1.
- Zero-count movr -> load_temp, then MOVE_CHECK retires immediately: no position write, no delay start.
- pause with run dropped during PAUSE_WAIT -> instruction completes on delay_done, then FSM holds in FETCH with all strobes 0 until run=1.

Source files
------------

// File: rtl/stepper_ctrl_pkg.sv
// Shared encodings for the stepper ASIP controller: states, mux/immediate/write-address
// codes, decoded instruction kinds and the bundled strobe record.
package stepper_ctrl_pkg;

  localparam int ROM_LATENCY_DEF = 1;
  localparam int FULL_STEP_DEF   = 2;
  localparam int HALF_STEP_DEF   = 1;

  typedef enum logic [3:0] {
    ST_FETCH      = 4'd0,
    ST_EXEC       = 4'd1,
    ST_MOVE_CHECK = 4'd2,
    ST_MOVE_WAIT  = 4'd3,
    ST_PAUSE_WAIT = 4'd4
  } state_t;

  localparam logic [1:0] OP1_PC  = 2'd0;
  localparam logic [1:0] OP1_REG = 2'd1;
  localparam logic [1:0] OP1_R0  = 2'd2;
  localparam logic [1:0] OP1_POS = 2'd3;

  localparam logic [1:0] OP2_REG = 2'd0;
  localparam logic [1:0] OP2_IMM = 2'd1;

  localparam logic [1:0] IMM_BR     = 2'd0;
  localparam logic [1:0] IMM_ARITH  = 2'd1;
  localparam logic [1:0] IMM_NIBBLE = 2'd2;
  localparam logic [1:0] IMM_ZERO   = 2'd3;

  localparam logic [1:0] WA_F0  = 2'd0;
  localparam logic [1:0] WA_F1  = 2'd1;
  localparam logic [1:0] WA_POS = 2'd2;
  localparam logic [1:0] WA_R0  = 2'd3;

  typedef enum logic [3:0] {
    I_NOP, I_BR, I_BRZ, I_ADDI, I_SUBI, I_SR0, I_SRH0,
    I_CLR, I_MOV, I_MOVA, I_MOVR, I_MOVRHS, I_PAUSE
  } instr_t;

  typedef struct packed {
    logic br;
    logic brz;
    logic addi;
    logic subi;
    logic sr0;
    logic srh0;
    logic clr;
    logic mov;
    logic mova;
    logic movr;
    logic movrhs;
    logic pause;
  } flags_t;

  typedef struct packed {
    logic       write_reg_file;
    logic       result_mux_select;
    logic [1:0] op1_sel;
    logic [1:0] op2_sel;
    logic       start_dly;
    logic       enable_dly;
    logic       commit_branch;
    logic       increment_pc;
    logic       alu_add_sub;
    logic       alu_set_low;
    logic       alu_set_high;
    logic       load_temp;
    logic       increment_temp;
    logic       decrement_temp;
    logic [1:0] sel_imm;
    logic [1:0] sel_wa;
  } strobes_t;

  // br and brz outrank everything; among the rest exactly one flag must be set, else NOP.
  function automatic instr_t classify(flags_t f);
    logic [9:0] rest;
    instr_t     r;
    rest = {f.addi, f.subi, f.sr0, f.srh0, f.clr, f.mov, f.mova, f.movr, f.movrhs, f.pause};
    r    = I_NOP;
    if (f.br) begin
      r = I_BR;
    end else if (f.brz) begin
      r = I_BRZ;
    end else begin
      case (rest)
        10'b10_0000_0000: r = I_ADDI;
        10'b01_0000_0000: r = I_SUBI;
        10'b00_1000_0000: r = I_SR0;
        10'b00_0100_0000: r = I_SRH0;
        10'b00_0010_0000: r = I_CLR;
        10'b00_0001_0000: r = I_MOV;
        10'b00_0000_1000: r = I_MOVA;
        10'b00_0000_0100: r = I_MOVR;
        10'b00_0000_0010: r = I_MOVRHS;
        10'b00_0000_0001: r = I_PAUSE;
        default:          r = I_NOP;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/stepper_control_fsm_output_decode.sv
// Combinational strobe decode: current state plus decoded instruction and status flags
// in, every datapath control strobe out. Reset forces all strobes low.
module ctrl_output_decode
  import stepper_ctrl_pkg::*;
(
  input  logic       reset_i,
  input  state_t     state_i,
  input  instr_t     instr_i,
  input  logic       r0_zero_i,
  input  logic       move_retire_i,
  input  logic       temp_neg_i,
  input  logic       delay_done_i,
  input  logic [1:0] step_i,
  output strobes_t   strobes_o
);

  strobes_t s;

  always_comb begin
    s = '0;
    if (!reset_i) begin
      case (state_i)
        ST_EXEC: begin
          case (instr_i)
            I_BR, I_BRZ: begin
              if (instr_i == I_BR || r0_zero_i) begin
                s.op1_sel       = OP1_PC;
                s.op2_sel       = OP2_IMM;
                s.sel_imm       = IMM_BR;
                s.commit_branch = 1'b1;
              end else begin
                s.increment_pc = 1'b1;
              end
            end
            I_ADDI, I_SUBI: begin
              s.write_reg_file = 1'b1;
              s.op1_sel        = OP1_REG;
              s.op2_sel        = OP2_IMM;
              s.sel_imm        = IMM_ARITH;
              s.alu_add_sub    = (instr_i == I_SUBI);
              s.sel_wa         = WA_F0;
              s.increment_pc   = 1'b1;
            end
            I_SR0, I_SRH0: begin
              s.write_reg_file = 1'b1;
              s.op1_sel        = OP1_R0;
              s.op2_sel        = OP2_IMM;
              s.sel_imm        = IMM_NIBBLE;
              s.alu_set_low    = (instr_i == I_SR0);
              s.alu_set_high   = (instr_i == I_SRH0);
              s.sel_wa         = WA_R0;
              s.increment_pc   = 1'b1;
            end
            I_CLR: begin
              s.write_reg_file = 1'b1;
              s.op1_sel        = OP1_REG;
              s.op2_sel        = OP2_REG;
              s.alu_add_sub    = 1'b1;
              s.sel_wa         = WA_F0;
              s.increment_pc   = 1'b1;
            end
            I_MOV: begin
              s.write_reg_file = 1'b1;
              s.op1_sel        = OP1_REG;
              s.op2_sel        = OP2_IMM;
              s.sel_imm        = IMM_ZERO;
              s.sel_wa         = WA_F1;
              s.increment_pc   = 1'b1;
            end
            I_MOVA: begin
              s.write_reg_file = 1'b1;
              s.op1_sel        = OP1_REG;
              s.op2_sel        = OP2_IMM;
              s.sel_imm        = IMM_ZERO;
              s.sel_wa         = WA_POS;
              s.start_dly      = 1'b1;
            end
            I_MOVR, I_MOVRHS: s.load_temp = 1'b1;
            I_PAUSE:          s.start_dly = 1'b1;
            default:          s.increment_pc = 1'b1;
          endcase
        end
        ST_MOVE_CHECK: begin
          if (move_retire_i) begin
            s.increment_pc = 1'b1;
          end else begin
            // The immediate select carries the latched step size itself during moves.
            s.write_reg_file = 1'b1;
            s.op1_sel        = OP1_POS;
            s.op2_sel        = OP2_IMM;
            s.sel_imm        = step_i;
            s.sel_wa         = WA_POS;
            s.start_dly      = 1'b1;
            s.alu_add_sub    = temp_neg_i;
            s.increment_temp = temp_neg_i;
            s.decrement_temp = !temp_neg_i;
          end
        end
        ST_MOVE_WAIT: s.enable_dly = 1'b1;
        ST_PAUSE_WAIT: begin
          s.enable_dly   = 1'b1;
          s.increment_pc = delay_done_i;
        end
        default: s = '0;
      endcase
    end
  end

  assign strobes_o = s;

endmodule

// File: rtl/stepper_control_fsm.sv
// Stepper ASIP main controller: fetch timing, instruction sequencing and the
// multi-cycle move/pause loops. Strobes come from ctrl_output_decode.
module stepper_control_fsm
  import stepper_ctrl_pkg::*;
#(
  parameter int ROM_LATENCY = ROM_LATENCY_DEF,
  parameter int FULL_STEP   = FULL_STEP_DEF,
  parameter int HALF_STEP   = HALF_STEP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       br,
  input  logic       brz,
  input  logic       addi,
  input  logic       subi,
  input  logic       sr0,
  input  logic       srh0,
  input  logic       clr,
  input  logic       mov,
  input  logic       mova,
  input  logic       movr,
  input  logic       movrhs,
  input  logic       pause,
  input  logic       delay_done,
  input  logic       temp_is_positive,
  input  logic       temp_is_negative,
  input  logic       temp_is_zero,
  input  logic       register0_is_zero,
  output logic       write_reg_file,
  output logic       result_mux_select,
  output logic [1:0] op1_mux_select,
  output logic [1:0] op2_mux_select,
  output logic       start_delay_counter,
  output logic       enable_delay_counter,
  output logic       commit_branch,
  output logic       increment_pc,
  output logic       alu_add_sub,
  output logic       alu_set_low,
  output logic       alu_set_high,
  output logic       load_temp,
  output logic       increment_temp,
  output logic       decrement_temp,
  output logic [1:0] select_immediate,
  output logic [1:0] select_write_address,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [1:0] fetch_cnt_q, fetch_cnt_d;
  logic [1:0] step_q, step_d;
  flags_t     flags;
  instr_t     instr;
  logic       fetch_done;
  logic       move_retire;
  strobes_t   strobes;

  assign flags       = {br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause};
  assign instr       = classify(flags);
  assign fetch_done  = (fetch_cnt_q == 2'(ROM_LATENCY - 1));
  // A temp with no sign flag set is treated as exhausted so a move can never spin.
  assign move_retire = temp_is_zero || !(temp_is_positive || temp_is_negative);

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    step_d      = step_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_done) begin
          // With run low the count parks at terminal so EXEC follows as soon as run returns.
          if (run) begin
            state_d     = ST_EXEC;
            fetch_cnt_d = 2'd0;
          end
        end else begin
          fetch_cnt_d = fetch_cnt_q + 2'd1;
        end
      end
      ST_EXEC: begin
        case (instr)
          I_MOVR: begin
            step_d  = 2'(FULL_STEP);
            state_d = ST_MOVE_CHECK;
          end
          I_MOVRHS: begin
            step_d  = 2'(HALF_STEP);
            state_d = ST_MOVE_CHECK;
          end
          I_MOVA, I_PAUSE: state_d = ST_PAUSE_WAIT;
          default:         state_d = ST_FETCH;
        endcase
      end
      ST_MOVE_CHECK: state_d = move_retire ? ST_FETCH : ST_MOVE_WAIT;
      ST_MOVE_WAIT:  if (delay_done) state_d = ST_MOVE_CHECK;
      ST_PAUSE_WAIT: if (delay_done) state_d = ST_FETCH;
      default:       state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      fetch_cnt_q <= 2'd0;
      step_q      <= 2'(FULL_STEP);
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      step_q      <= step_d;
    end
  end

  ctrl_output_decode u_decode (
    .reset_i       (reset),
    .state_i       (state_q),
    .instr_i       (instr),
    .r0_zero_i     (register0_is_zero),
    .move_retire_i (move_retire),
    .temp_neg_i    (temp_is_negative),
    .delay_done_i  (delay_done),
    .step_i        (step_q),
    .strobes_o     (strobes)
  );

  assign write_reg_file       = strobes.write_reg_file;
  assign result_mux_select    = strobes.result_mux_select;
  assign op1_mux_select       = strobes.op1_sel;
  assign op2_mux_select       = strobes.op2_sel;
  assign start_delay_counter  = strobes.start_dly;
  assign enable_delay_counter = strobes.enable_dly;
  assign commit_branch        = strobes.commit_branch;
  assign increment_pc         = strobes.increment_pc;
  assign alu_add_sub          = strobes.alu_add_sub;
  assign alu_set_low          = strobes.alu_set_low;
  assign alu_set_high         = strobes.alu_set_high;
  assign load_temp            = strobes.load_temp;
  assign increment_temp       = strobes.increment_temp;
  assign decrement_temp       = strobes.decrement_temp;
  assign select_immediate     = strobes.sel_imm;
  assign select_write_address = strobes.sel_wa;
  assign state                = reset ? ST_FETCH : state_q;

endmodule
